// File: rtl/iter_shifter.sv
// Multi-cycle shifter: shifts or rotates-left the operand one bit per clock,
// flags busy while iterating and pulses done when the result is ready.
module iter_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       control,
    input  logic [4:0]       shamt,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    state_t           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] work_q;
    logic [4:0]       count_q;
    logic [WIDTH-1:0] step_d;

    // One-bit step of the working register for the latched operation.
    always_comb begin
        step_d = work_q;
        case (op_q)
            OP_LSL:  step_d = {work_q[WIDTH-2:0], 1'b0};
            OP_LSR:  step_d = {1'b0, work_q[WIDTH-1:1]};
            OP_ASR:  step_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            OP_ROL:  step_d = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            default: step_d = work_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_LSL;
            work_q  <= '0;
            count_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q    <= control;
                        work_q  <= data_in;
                        count_q <= shamt;
                        if (shamt != 5'd0) begin
                            state_q <= S_SHIFT;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end else begin
                            state_q <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    // start is ignored here; the operation in flight runs to completion.
                    work_q  <= step_d;
                    count_q <= count_q - 5'd1;
                    if (count_q == 5'd1) begin
                        state_q <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    assign data_out = work_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter (WIDTH=8): expected results are queued at
// launch and compared against data_out on the done pulse.
module tb_iter_shifter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] control;
    logic [4:0] shamt;
    logic [7:0] data_in;
    logic       busy;
    logic       done;
    logic [7:0] data_out;

    int checks = 0;
    int passes = 0;
    logic [7:0] exp_q[$];

    iter_shifter #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .control  (control),
        .shamt    (shamt),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [1:0] c, input int a, input logic [7:0] d);
        logic [7:0] r;
        int k;
        case (c)
            2'd0:    r = d << a;
            2'd1:    r = d >> a;
            2'd2:    r = $signed(d) >>> a;
            default: begin
                k = a % 8;
                r = (d << k) | (d >> (8 - k));
            end
        endcase
        return r;
    endfunction

    task automatic launch(input logic [1:0] c, input int a, input logic [7:0] d);
        @(negedge clk);
        start   = 1'b1;
        control = c;
        shamt   = 5'(a);
        data_in = d;
        exp_q.push_back(model(c, a, d));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_single_op(input string name, input logic [1:0] c, input int a, input logic [7:0] d);
        int n, bc, exp_n;
        logic [7:0] exp;
        launch(c, a, d);
        wait_done(n, bc);
        exp_n = (a == 0) ? 1 : a + 1;
        exp = exp_q.pop_front();
        $display("op %s ctl=%0d shamt=%0d din=%h -> dout=%h done_cycle=%0d busy_cycles=%0d",
                 name, c, a, d, data_out, n, bc);
        checks++;
        if (n !== exp_n) $display("FAIL %s latency: done at cycle %0d, required %0d", name, n, exp_n);
        else passes++;
        checks++;
        if (bc !== a) $display("FAIL %s busy_cycles: got %0d, required %0d", name, bc, a);
        else passes++;
        checks++;
        if (data_out !== exp) $display("FAIL %s data_out: got %h, required %h", name, data_out, exp);
        else passes++;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) $display("FAIL %s idle_after_done: busy,done=%b, required 00", name, {busy, done});
        else passes++;
        checks++;
        if (data_out !== exp) $display("FAIL %s hold: data_out %h, required %h", name, data_out, exp);
        else passes++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, data_out} !== 10'd0) $display("FAIL reset_state: busy,done,data_out=%b,%b,%h required 0,0,00", busy, done, data_out);
        else passes++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, data_out} !== 10'd0) $display("FAIL reset_release: busy,done,data_out=%b,%b,%h required 0,0,00", busy, done, data_out);
        else passes++;
        $display("reset: busy=%b done=%b dout=%h", busy, done, data_out);
    endtask

    task automatic test_lsl();
        test_single_op("lsl_81_1", 2'd0, 1, 8'h81);
    endtask

    task automatic test_asr();
        test_single_op("asr_90_3", 2'd2, 3, 8'h90);
        test_single_op("asr_70_3", 2'd2, 3, 8'h70);
    endtask

    task automatic test_rol();
        test_single_op("rol_a1_4", 2'd3, 4, 8'hA1);
        test_single_op("rol_a1_9", 2'd3, 9, 8'hA1);
    endtask

    task automatic test_large_and_zero();
        test_single_op("lsr_ff_10", 2'd1, 10, 8'hFF);
        test_single_op("zero_5c_0", 2'd1, 0, 8'h5C);
        test_single_op("asr_80_31", 2'd2, 31, 8'h80);
    endtask

    task automatic test_ignore_start();
        int n, bc;
        logic [7:0] exp;
        launch(2'd0, 5, 8'h01);
        @(negedge clk);
        @(negedge clk);
        start   = 1'b1;
        control = 2'd3;
        shamt   = 5'd2;
        data_in = 8'hFF;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n, bc);
        exp = exp_q.pop_front();
        $display("op ignore_start ctl=0 shamt=5 din=01 -> dout=%h done_cycle=%0d", data_out, n + 2);
        checks++;
        if (n + 2 !== 6) $display("FAIL ignore_start latency: done at cycle %0d, required 6", n + 2);
        else passes++;
        checks++;
        if (data_out !== exp) $display("FAIL ignore_start data_out: got %h, required %h", data_out, exp);
        else passes++;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) $display("FAIL ignore_start idle: busy,done=%b, required 00", {busy, done});
        else passes++;
    endtask

    task automatic test_back_to_back();
        int n, bc;
        logic [7:0] exp;
        launch(2'd2, 3, 8'h70);
        wait_done(n, bc);
        exp = exp_q.pop_front();
        checks++;
        if (data_out !== exp) $display("FAIL b2b_first data_out: got %h, required %h", data_out, exp);
        else passes++;
        start   = 1'b1;
        control = 2'd3;
        shamt   = 5'd2;
        data_in = 8'h81;
        exp_q.push_back(model(2'd3, 2, 8'h81));
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n, bc);
        exp = exp_q.pop_front();
        $display("op b2b_second ctl=3 shamt=2 din=81 -> dout=%h done_cycle=%0d busy_cycles=%0d", data_out, n, bc);
        checks++;
        if (n !== 3 || bc !== 2) $display("FAIL b2b_second timing: done_cycle=%0d busy=%0d, required 3 and 2", n, bc);
        else passes++;
        checks++;
        if (data_out !== exp) $display("FAIL b2b_second data_out: got %h, required %h", data_out, exp);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen_done;
        launch(2'd0, 6, 8'h01);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) $display("FAIL reset_mid busy_before: got %b, required 1", busy);
        else passes++;
        #2 rst_n = 1'b0;
        #1;
        void'(exp_q.pop_front());
        $display("reset_mid: busy=%b done=%b dout=%h", busy, done, data_out);
        checks++;
        if ({busy, done, data_out} !== 10'd0) $display("FAIL reset_mid async: busy,done,data_out=%b,%b,%h required 0,0,00", busy, done, data_out);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) $display("FAIL reset_mid stale_activity: got %b, required 0", seen_done);
        else passes++;
        test_single_op("after_reset", 2'd3, 3, 8'hC3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            test_single_op("random", 2'($urandom_range(0, 3)), int'($urandom_range(0, 20)), 8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        control = 2'd0;
        shamt   = 5'd0;
        data_in = 8'h00;
        test_reset();
        test_lsl();
        test_asr();
        test_rol();
        test_large_and_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
